cnt4b_mon: RTL

Sequence monitor for the 4-bit up/down wrap counter: samples the counter's output bus together with the same MIN/MAX configuration and checks every step against the counter's legal behaviour. It infers the counting direction, flags wrap-around and stopped (hold) cycles, and reports illegal transitions. It sits beside the counter in test and debug builds.

---
 rtl/cnt4b_mon.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cnt4b_mon.sv
// cnt4b_mon: sequence monitor for the 4-bit up/down wrap counter.
// Checks each sampled counter value against the legal next values derived
// from the previous sample and the MIN/MAX range. It infers the counting
// direction and flags hold, wrap, direction-change and illegal steps.
module cnt4b_mon (
  input  logic       clk,
  input  logic       rst,
  input  logic       CLR,
  input  logic       VALID,
  input  logic [3:0] CNT_IN,
  input  logic [3:0] MIN,
  input  logic [3:0] MAX,
  output logic       DIR,
  output logic       LOCKED,
  output logic       HOLD,
  output logic       WRAP,
  output logic       DIR_CHG,
  output logic       ERR,
  output logic [7:0] ERR_CNT,
  output logic       CFG_ERR
);

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, LOCK, TRACK_UP, TRACK_DN} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] prev, prev_nxt;
  logic [DW-1:0] exp_up, exp_dn;
  logic [CW-1:0] err_cnt_nxt;
  logic          cfg_bad, in_range, is_prev, is_up, is_dn;
  logic          dir_nxt, locked_nxt, hold_nxt, wrap_nxt, chg_nxt, err_nxt;

  // Legal successors of the previous sample within the configured range
  always_comb begin
    cfg_bad  = (MIN > MAX);
    in_range = (CNT_IN >= MIN) && (CNT_IN <= MAX);
    exp_up   = (prev == MAX) ? MIN : prev + DW'(1);
    exp_dn   = (prev == MIN) ? MAX : prev - DW'(1);
    is_prev  = (CNT_IN == prev);
    is_up    = (CNT_IN == exp_up);
    is_dn    = (CNT_IN == exp_dn);
  end

  // Next-state and next-output decode for one sample
  always_comb begin
    state_nxt   = state;
    prev_nxt    = prev;
    dir_nxt     = DIR;
    hold_nxt    = 1'b0;
    wrap_nxt    = 1'b0;
    chg_nxt     = 1'b0;
    err_nxt     = 1'b0;
    err_cnt_nxt = ERR_CNT;

    if (CLR) begin
      state_nxt   = IDLE;
      err_cnt_nxt = '0;
    end else if (cfg_bad) begin
      state_nxt = IDLE;
    end else if (VALID) begin
      if (!in_range) begin
        err_nxt   = 1'b1;
        state_nxt = IDLE;
      end else begin
        prev_nxt = CNT_IN;
        case (state)
          IDLE: state_nxt = LOCK;
          LOCK: begin
            if (is_prev) begin
              hold_nxt = 1'b1;
            end else if (is_up && is_dn) begin
              state_nxt = LOCK;
            end else if (is_up) begin
              state_nxt = TRACK_UP;
              dir_nxt   = 1'b1;
            end else if (is_dn) begin
              state_nxt = TRACK_DN;
              dir_nxt   = 1'b0;
            end else begin
              err_nxt = 1'b1;
            end
          end
          TRACK_UP: begin
            if (is_prev) begin
              hold_nxt = 1'b1;
            end else if (is_up) begin
              wrap_nxt = (prev == MAX);
            end else if (is_dn) begin
              state_nxt = TRACK_DN;
              dir_nxt   = 1'b0;
              chg_nxt   = 1'b1;
              wrap_nxt  = (prev == MIN);
            end else begin
              err_nxt   = 1'b1;
              state_nxt = LOCK;
            end
          end
          TRACK_DN: begin
            if (is_prev) begin
              hold_nxt = 1'b1;
            end else if (is_dn) begin
              wrap_nxt = (prev == MIN);
            end else if (is_up) begin
              state_nxt = TRACK_UP;
              dir_nxt   = 1'b1;
              chg_nxt   = 1'b1;
              wrap_nxt  = (prev == MAX);
            end else begin
              err_nxt   = 1'b1;
              state_nxt = LOCK;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
      if (err_nxt && (ERR_CNT != '1)) begin
        err_cnt_nxt = ERR_CNT + CW'(1);
      end
    end

    locked_nxt = (state_nxt == TRACK_UP) || (state_nxt == TRACK_DN);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      prev    <= '0;
      DIR     <= 1'b1;
      LOCKED  <= 1'b0;
      HOLD    <= 1'b0;
      WRAP    <= 1'b0;
      DIR_CHG <= 1'b0;
      ERR     <= 1'b0;
      ERR_CNT <= '0;
      CFG_ERR <= 1'b0;
    end else begin
      state   <= state_nxt;
      prev    <= prev_nxt;
      DIR     <= dir_nxt;
      LOCKED  <= locked_nxt;
      HOLD    <= hold_nxt;
      WRAP    <= wrap_nxt;
      DIR_CHG <= chg_nxt;
      ERR     <= err_nxt;
      ERR_CNT <= err_cnt_nxt;
      CFG_ERR <= cfg_bad;
    end
  end

endmodule
